// File: rtl/posit_mul_sequencer_if.sv
// Job handshake and per-stage start/done bundle between the posit multiply
// sequencer (slave) and the top level / datapath stages that drive it (master).
interface posit_mul_sequencer_if;
  logic       start;
  logic       busy;
  logic       done;
  logic [1:0] special;
  logic       error;
  logic       stage_rst;
  logic       dec_start;
  logic       dec_done_a;
  logic       dec_done_b;
  logic       zero_a;
  logic       nar_a;
  logic       zero_b;
  logic       nar_b;
  logic       mul_load;
  logic       mul_done;
  logic       exp_start;
  logic       exp_done;
  logic       exp_nar;
  logic       exp_zero;
  logic       adj_start;
  logic       adj_done;
  logic       rnd_start;
  logic       rnd_done;
  logic       enc_start;
  logic       enc_done;

  modport master (
    output start, dec_done_a, dec_done_b, zero_a, nar_a, zero_b, nar_b,
           mul_done, exp_done, exp_nar, exp_zero, adj_done, rnd_done, enc_done,
    input  busy, done, special, error, stage_rst, dec_start, mul_load,
           exp_start, adj_start, rnd_start, enc_start
  );

  modport slave (
    input  start, dec_done_a, dec_done_b, zero_a, nar_a, zero_b, nar_b,
           mul_done, exp_done, exp_nar, exp_zero, adj_done, rnd_done, enc_done,
    output busy, done, special, error, stage_rst, dec_start, mul_load,
           exp_start, adj_start, rnd_start, enc_start
  );
endinterface

// File: rtl/posit_mul_sequencer.sv
// Job-level FSM for one posit32 multiply: decode, mul/exp, adjust, round,
// encode, with ZERO/NaR short-circuits and a per-stage watchdog.
module posit_mul_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input logic                  clk,
  input logic                  rst,
  posit_mul_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_MUL_EXP, S_ADJUST, S_ROUND, S_ENCODE, S_DONE
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               da_q, db_q, za_q, na_q, zb_q, nb_q, mul_q, exp_q;
  logic               busy_q, done_q, error_q, stage_rst_q, dec_start_q;
  logic               mul_load_q, exp_start_q, adj_start_q, rnd_start_q, enc_start_q;
  logic [1:0]         special_q;

  logic               da_d, db_d, za_d, na_d, zb_d, nb_d, mul_d, exp_d;
  logic               timeout_d, fin_d, adv_d, err_d;
  logic [1:0]         sp_d;

  // Flags are captured only with the first done of each decoder.
  always_comb begin
    da_d      = da_q | bus.dec_done_a;
    db_d      = db_q | bus.dec_done_b;
    za_d      = za_q | (bus.dec_done_a & ~da_q & bus.zero_a);
    na_d      = na_q | (bus.dec_done_a & ~da_q & bus.nar_a);
    zb_d      = zb_q | (bus.dec_done_b & ~db_q & bus.zero_b);
    nb_d      = nb_q | (bus.dec_done_b & ~db_q & bus.nar_b);
    mul_d     = mul_q | bus.mul_done;
    exp_d     = exp_q | bus.exp_done;
    timeout_d = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    fin_d     = 1'b0;
    adv_d     = 1'b0;
    err_d     = 1'b0;
    sp_d      = 2'b00;
    // Completion is evaluated before the watchdog so it wins a tie.
    case (state_q)
      S_DECODE: begin
        if (da_d && db_d) begin
          if (na_d || nb_d) begin
            fin_d = 1'b1;
            sp_d  = 2'b10;
          end else if (za_d || zb_d) begin
            fin_d = 1'b1;
            sp_d  = 2'b01;
          end else begin
            adv_d = 1'b1;
          end
        end
      end
      S_MUL_EXP: begin
        if (bus.exp_done && bus.exp_nar) begin
          fin_d = 1'b1;
          sp_d  = 2'b10;
        end else if (bus.exp_done && bus.exp_zero) begin
          fin_d = 1'b1;
          sp_d  = 2'b01;
        end else if (mul_d && exp_d) begin
          adv_d = 1'b1;
        end
      end
      S_ADJUST: adv_d = bus.adj_done;
      S_ROUND:  adv_d = bus.rnd_done;
      S_ENCODE: fin_d = bus.enc_done;
      default:  ;
    endcase
    if (!fin_d && !adv_d && state_q != S_IDLE && state_q != S_DONE && timeout_d) begin
      fin_d = 1'b1;
      sp_d  = 2'b10;
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      {da_q, db_q, za_q, na_q, zb_q, nb_q, mul_q, exp_q} <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      special_q   <= '0;
      stage_rst_q <= 1'b0;
      dec_start_q <= 1'b0;
      mul_load_q  <= 1'b0;
      exp_start_q <= 1'b0;
      adj_start_q <= 1'b0;
      rnd_start_q <= 1'b0;
      enc_start_q <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      stage_rst_q <= 1'b0;
      dec_start_q <= 1'b0;
      mul_load_q  <= 1'b0;
      exp_start_q <= 1'b0;
      adj_start_q <= 1'b0;
      rnd_start_q <= 1'b0;
      enc_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q     <= S_DECODE;
            busy_q      <= 1'b1;
            stage_rst_q <= 1'b1;
            dec_start_q <= 1'b1;
            special_q   <= '0;
            error_q     <= 1'b0;
            cnt_q       <= '0;
            {da_q, db_q, za_q, na_q, zb_q, nb_q, mul_q, exp_q} <= '0;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          cnt_q <= cnt_q + 1'b1;
          if (state_q == S_DECODE) begin
            {da_q, db_q, za_q, na_q, zb_q, nb_q} <= {da_d, db_d, za_d, na_d, zb_d, nb_d};
          end
          if (state_q == S_MUL_EXP) begin
            mul_q <= mul_d;
            exp_q <= exp_d;
          end
          if (fin_d) begin
            state_q   <= S_DONE;
            done_q    <= 1'b1;
            special_q <= sp_d;
            error_q   <= err_d;
          end else if (adv_d) begin
            cnt_q <= '0;
            case (state_q)
              S_DECODE: begin
                state_q     <= S_MUL_EXP;
                mul_load_q  <= 1'b1;
                exp_start_q <= 1'b1;
                mul_q       <= 1'b0;
                exp_q       <= 1'b0;
              end
              S_MUL_EXP: begin
                state_q     <= S_ADJUST;
                adj_start_q <= 1'b1;
              end
              S_ADJUST: begin
                state_q     <= S_ROUND;
                rnd_start_q <= 1'b1;
              end
              default: begin
                state_q     <= S_ENCODE;
                enc_start_q <= 1'b1;
              end
            endcase
          end
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.special   = special_q;
  assign bus.error     = error_q;
  assign bus.stage_rst = stage_rst_q;
  assign bus.dec_start = dec_start_q;
  assign bus.mul_load  = mul_load_q;
  assign bus.exp_start = exp_start_q;
  assign bus.adj_start = adj_start_q;
  assign bus.rnd_start = rnd_start_q;
  assign bus.enc_start = enc_start_q;

endmodule

// File: tb/tb_posit_mul_sequencer.sv
// Directed bench for posit_mul_sequencer: table of job scenarios with
// per-stage response delays, plus reset-in-ROUND and stray-pulse sequences.
module tb_posit_mul_sequencer;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  posit_mul_sequencer_if bus();

  posit_mul_sequencer #(.TIMEOUT_CYCLES(255), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Delays are cycles after the stage's start pulse; -1 means never respond.
  typedef struct {
    int         da, db;
    bit         za, na, zb, nb;
    int         dm, de;
    bit         ez, en;
    int         dadj, drnd, denc;
    int         xdone;
    logic [1:0] xsp;
    bit         xerr;
    bit         xmul;
    bit         hold;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.start      = 1'b0;
    bus.dec_done_a = 1'b0;
    bus.dec_done_b = 1'b0;
    bus.zero_a     = 1'b0;
    bus.nar_a      = 1'b0;
    bus.zero_b     = 1'b0;
    bus.nar_b      = 1'b0;
    bus.mul_done   = 1'b0;
    bus.exp_done   = 1'b0;
    bus.exp_nar    = 1'b0;
    bus.exp_zero   = 1'b0;
    bus.adj_done   = 1'b0;
    bus.rnd_done   = 1'b0;
    bus.enc_done   = 1'b0;
  endtask

  function automatic logic [11:0] all_outs();
    return {bus.busy, bus.done, bus.special, bus.error, bus.stage_rst, bus.dec_start,
            bus.mul_load, bus.exp_start, bus.adj_start, bus.rnd_start, bus.enc_start};
  endfunction

  function automatic int due(input int n, input int d);
    return (d < 0) ? -1 : n + d;
  endfunction

  task automatic run_job(input vec_t v, input int id);
    int due_a, due_b, due_m, due_e, due_adj, due_rnd, due_enc, done_at;
    bit mul_seen;
    due_a = -1; due_b = -1; due_m = -1; due_e = -1;
    due_adj = -1; due_rnd = -1; due_enc = -1;
    done_at = -1;
    mul_seen = 1'b0;
    @(posedge clk); #1;
    clear_inputs();
    bus.start = 1'b1;
    for (int n = 1; n <= 400; n++) begin
      @(posedge clk); #1;
      clear_inputs();
      bus.start = v.hold && (n <= 10);
      if (n == 1) begin
        check($sformatf("vec%0d_launch", id),
              {bus.busy, bus.stage_rst, bus.dec_start, bus.special, bus.error}, 6'b111000);
      end
      if (bus.dec_start) begin
        due_a = due(n, v.da);
        due_b = due(n, v.db);
      end
      if (bus.mul_load) begin
        mul_seen = 1'b1;
        due_m = due(n, v.dm);
      end
      if (bus.exp_start) due_e   = due(n, v.de);
      if (bus.adj_start) due_adj = due(n, v.dadj);
      if (bus.rnd_start) due_rnd = due(n, v.drnd);
      if (bus.enc_start) due_enc = due(n, v.denc);
      if (bus.done && done_at < 0) begin
        done_at = n;
        check($sformatf("vec%0d_special", id), bus.special, v.xsp);
        check($sformatf("vec%0d_error", id), bus.error, v.xerr);
        check($sformatf("vec%0d_busy_at_done", id), bus.busy, 1);
      end
      if (done_at >= 0 && n == done_at + 1) begin
        check($sformatf("vec%0d_after_done", id),
              {bus.done, bus.busy, bus.special, bus.error}, {2'b00, v.xsp, v.xerr});
        break;
      end
      bus.dec_done_a = (n == due_a);
      bus.zero_a     = (n == due_a) && v.za;
      bus.nar_a      = (n == due_a) && v.na;
      bus.dec_done_b = (n == due_b);
      bus.zero_b     = (n == due_b) && v.zb;
      bus.nar_b      = (n == due_b) && v.nb;
      bus.mul_done   = (n == due_m);
      bus.exp_done   = (n == due_e);
      bus.exp_zero   = (n == due_e) && v.ez;
      bus.exp_nar    = (n == due_e) && v.en;
      bus.adj_done   = (n == due_adj);
      bus.rnd_done   = (n == due_rnd);
      bus.enc_done   = (n == due_enc);
    end
    clear_inputs();
    check($sformatf("vec%0d_done_cycle", id), done_at, v.xdone);
    check($sformatf("vec%0d_mul_load_seen", id), mul_seen, v.xmul);
  endtask

  initial begin
    int seen_done;
    total = 0;
    bad   = 0;
    //          da  db za na zb nb  dm  de ez en adj rnd enc done sp    err mul hold
    vecs[0]  = '{ 1, 1, 0, 0, 0, 0,  1,  1, 0, 0,  1,  1,  1,  11, 2'b00, 0, 1, 0};
    vecs[1]  = '{ 1, 3, 0, 0, 1, 0,  1,  1, 0, 0,  1,  1,  1,   5, 2'b01, 0, 0, 0};
    vecs[2]  = '{ 1, 1, 0, 1, 1, 0,  1,  1, 0, 0,  1,  1,  1,   3, 2'b10, 0, 0, 0};
    vecs[3]  = '{ 1, 1, 0, 0, 0, 0, -1,  1, 1, 0,  1,  1,  1,   5, 2'b01, 0, 1, 0};
    vecs[4]  = '{ 1, 1, 0, 0, 0, 0,  1,  1, 0, 0, -1,  1,  1, 260, 2'b10, 1, 1, 0};
    vecs[5]  = '{ 1, 1, 0, 0, 0, 0,  1,  1, 0, 0, 254, 1,  1, 264, 2'b00, 0, 1, 0};
    vecs[6]  = '{ 0, 0, 0, 0, 0, 0,  0,  0, 0, 0,  0,  0,  0,   6, 2'b00, 0, 1, 0};
    vecs[7]  = '{ 1, 1, 0, 0, 0, 0,  1,  2, 1, 1,  1,  1,  1,   6, 2'b10, 0, 1, 0};
    vecs[8]  = '{-1, 1, 0, 0, 0, 0,  1,  1, 0, 0,  1,  1,  1, 256, 2'b10, 1, 0, 0};
    vecs[9]  = '{ 3, 1, 0, 0, 0, 0,  2,  1, 0, 0,  2,  3,  1,  17, 2'b00, 0, 1, 0};
    vecs[10] = '{ 1, 1, 0, 0, 0, 0,  1,  1, 0, 0,  1,  1,  1,  11, 2'b00, 0, 1, 1};
    vecs[11] = '{ 1, 2, 1, 0, 0, 1,  1,  1, 0, 0,  1,  1,  1,   4, 2'b10, 0, 0, 0};

    clear_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", all_outs(), 12'h000);
    rst = 1'b0;

    // Stray completions while idle must not launch or complete anything.
    @(posedge clk); #1;
    bus.enc_done = 1'b1;
    bus.dec_done_a = 1'b1;
    bus.dec_done_b = 1'b1;
    @(posedge clk); #1;
    clear_inputs();
    check("idle_stray_pulses", all_outs(), 12'h000);

    for (int i = 0; i < 12; i++) run_job(vecs[i], i);

    // Reset asserted while in ROUND abandons the job with no done pulse.
    @(posedge clk); #1;
    clear_inputs();
    bus.start = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      @(posedge clk); #1;
      clear_inputs();
      if (n == 7) check("reached_round", bus.rnd_start, 1);
      bus.dec_done_a = (n == 2);
      bus.dec_done_b = (n == 2);
      bus.mul_done   = (n == 4);
      bus.exp_done   = (n == 4);
      bus.adj_done   = (n == 6);
      rst            = (n == 7);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_job_reset_outputs", all_outs(), 12'h000);
    bus.rnd_done = 1'b1;
    bus.enc_done = 1'b1;
    seen_done = 0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      clear_inputs();
      if (bus.done || bus.busy) seen_done++;
    end
    check("no_done_after_reset", seen_done, 0);

    run_job(vecs[0], 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
